// File: rtl/knn_vote_pkg.sv
// Shared definitions for the KNN vote stage: neighbour entry layout, default widths and
// the FSM state encoding that the insert stage's bench also decodes.
package knn_vote_pkg;

    // Neighbour entry layout: {distance, label}
    localparam int unsigned LABEL_LSB   = 0;
    localparam int unsigned LABEL_MSB   = 7;
    localparam int unsigned DIST_LSB    = 8;

    localparam int unsigned NB_W_DEF    = 40;
    localparam int unsigned LABEL_W_DEF = LABEL_MSB - LABEL_LSB + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StVote    = 2'd2,
        StDone    = 2'd3
    } knn_state_e;

    // $clog2 that never returns 0, so single-entry tables still get a 1-bit index
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/knn_label_hist.sv
// Per-label vote histogram plus the beat position at which each label was first seen.
// One increment port (used while collecting) and one combinational read port (used while voting).
module knn_label_hist
    import knn_vote_pkg::*;
#(
    parameter int unsigned K        = 4,
    parameter int unsigned N_LABELS = 4,
    localparam int unsigned CNT_W   = $clog2(K + 1),
    localparam int unsigned POS_W   = clog2_min1(K),
    localparam int unsigned IDX_W   = clog2_min1(N_LABELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic [POS_W-1:0] inc_pos,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_count,
    output logic [POS_W-1:0] rd_first
);

    logic [CNT_W-1:0] hist_q  [N_LABELS];
    logic [POS_W-1:0] first_q [N_LABELS];

    // Counter/first-position update: clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_LABELS); i++) begin
                hist_q[i]  <= '0;
                first_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < int'(N_LABELS); i++) begin
                hist_q[i]  <= '0;
                first_q[i] <= '0;
            end
        end else if (inc) begin
            for (int i = 0; i < int'(N_LABELS); i++) begin
                if (inc_idx == IDX_W'(i)) begin
                    hist_q[i] <= hist_q[i] + CNT_W'(1);
                    // Only the earliest (nearest) occurrence is remembered
                    if (hist_q[i] == '0) begin
                        first_q[i] <= inc_pos;
                    end
                end
            end
        end
    end

    // Read mux; out-of-range indices read as zero
    always_comb begin
        rd_count = '0;
        rd_first = '0;
        for (int i = 0; i < int'(N_LABELS); i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_count = hist_q[i];
                rd_first = first_q[i];
            end
        end
    end

endmodule

// File: rtl/knn_vote.sv
// KNN majority vote: collects K neighbour entries from a valid/ready stream, builds a label
// histogram, then scans it one label per cycle to pick the winner. Ties go to the label whose
// first occurrence was nearest (earliest beat).
module knn_vote
    import knn_vote_pkg::*;
#(
    parameter int unsigned K        = 4,
    parameter int unsigned N_LABELS = 4,
    parameter int unsigned NB_W     = NB_W_DEF,
    parameter int unsigned LABEL_W  = LABEL_W_DEF,
    localparam int unsigned CNT_W   = $clog2(K + 1),
    localparam int unsigned POS_W   = clog2_min1(K),
    localparam int unsigned IDX_W   = clog2_min1(N_LABELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               nb_valid,
    output logic               nb_ready,
    input  logic [NB_W-1:0]    nb_data,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [LABEL_W-1:0] result_label,
    output logic [CNT_W-1:0]   result_count,
    output logic               bad_label,
    output logic               busy
);

    knn_state_e state_q, state_d;

    logic [POS_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]   vote_q, vote_d;
    logic [CNT_W-1:0]   best_count_q, best_count_d;
    logic [POS_W-1:0]   best_first_q, best_first_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [LABEL_W-1:0] res_label_q, res_label_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic               bad_q, bad_d;

    logic               hist_clear;
    logic               hist_inc;
    logic [CNT_W-1:0]   rd_count;
    logic [POS_W-1:0]   rd_first;

    logic [LABEL_W-1:0] label;
    logic               label_legal;
    logic               cand_win;
    logic               unused_dist;

    assign label       = nb_data[LABEL_LSB +: LABEL_W];
    assign label_legal = (32'(label) < N_LABELS);
    // Distance only orders the stream upstream; it carries no information here
    assign unused_dist = ^nb_data[NB_W-1:DIST_LSB];

    knn_label_hist #(
        .K        (K),
        .N_LABELS (N_LABELS)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clear    (hist_clear),
        .inc      (hist_inc),
        .inc_idx  (label[IDX_W-1:0]),
        .inc_pos  (beat_q),
        .rd_idx   (vote_q),
        .rd_count (rd_count),
        .rd_first (rd_first)
    );

    // Candidate vote_q displaces the running best on more votes, or equal nonzero votes
    // with an earlier first occurrence
    always_comb begin
        cand_win = (rd_count > best_count_q) ||
                   ((rd_count == best_count_q) && (rd_count != '0) &&
                    (rd_first < best_first_q));
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        vote_d       = vote_q;
        best_count_d = best_count_q;
        best_first_d = best_first_q;
        best_idx_d   = best_idx_q;
        res_label_d  = res_label_q;
        res_count_d  = res_count_q;
        bad_d        = bad_q;
        hist_clear   = 1'b0;
        hist_inc     = 1'b0;
        nb_ready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    hist_clear = 1'b1;
                    bad_d      = 1'b0;
                    beat_d     = '0;
                    state_d    = StCollect;
                end
            end
            StCollect: begin
                nb_ready = 1'b1;
                if (nb_valid) begin
                    if (label_legal) begin
                        hist_inc = 1'b1;
                    end else begin
                        bad_d = 1'b1;
                    end
                    beat_d = beat_q + POS_W'(1);
                    if (beat_q == POS_W'(K - 1)) begin
                        vote_d       = '0;
                        best_count_d = '0;
                        best_first_d = '0;
                        best_idx_d   = '0;
                        state_d      = StVote;
                    end
                end
            end
            StVote: begin
                if (cand_win) begin
                    best_count_d = rd_count;
                    best_first_d = rd_first;
                    best_idx_d   = vote_q;
                end
                vote_d = vote_q + IDX_W'(1);
                if (vote_q == IDX_W'(N_LABELS - 1)) begin
                    // With no legal labels best stays at label 0 / count 0
                    res_label_d = LABEL_W'(best_idx_d);
                    res_count_d = best_count_d;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            vote_q       <= '0;
            best_count_q <= '0;
            best_first_q <= '0;
            best_idx_q   <= '0;
            res_label_q  <= '0;
            res_count_q  <= '0;
            bad_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            vote_q       <= vote_d;
            best_count_q <= best_count_d;
            best_first_q <= best_first_d;
            best_idx_q   <= best_idx_d;
            res_label_q  <= res_label_d;
            res_count_q  <= res_count_d;
            bad_q        <= bad_d;
        end
    end

    assign result_valid = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign result_label = res_label_q;
    assign result_count = res_count_q;
    assign bad_label    = bad_q;

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote (K=4, N_LABELS=4): table of label patterns with hand-computed
// winners, plus hand-written stall/backpressure and mid-pass reset sequences.
module tb_knn_vote;

    localparam int unsigned K  = 4;
    localparam int unsigned NL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        nb_valid = 1'b0;
    logic        nb_ready;
    logic [39:0] nb_data = '0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [7:0]  result_label;
    logic [2:0]  result_count;
    logic        bad_label;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0][7:0] labs;
        int              exp_label;
        int              exp_count;
        int              exp_bad;
    } vec_t;

    vec_t vecs [8];

    knn_vote #(
        .K        (K),
        .N_LABELS (NL),
        .NB_W     (40),
        .LABEL_W  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .nb_valid     (nb_valid),
        .nb_ready     (nb_ready),
        .nb_data      (nb_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_label (result_label),
        .result_count (result_count),
        .bad_label    (bad_label),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input int l0, input int l1, input int l2, input int l3,
                                 input int el, input int ec, input int eb);
        vec_t v;
        v.labs[0]   = 8'(l0);
        v.labs[1]   = 8'(l1);
        v.labs[2]   = 8'(l2);
        v.labs[3]   = 8'(l3);
        v.exp_label = el;
        v.exp_count = ec;
        v.exp_bad   = eb;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " nb_ready"}, int'(nb_ready), 0);
        check({tag, " result_valid"}, int'(result_valid), 0);
        check({tag, " result_label"}, int'(result_label), 0);
        check({tag, " result_count"}, int'(result_count), 0);
        check({tag, " bad_label"}, int'(bad_label), 0);
        check({tag, " busy"}, int'(busy), 0);
    endtask

    // One full classification pass. gaps>0 inserts idle cycles (label 0 on the bus) between
    // beats and pulses start during the first gap; keep_valid leaves a label-0 beat offered
    // after the K-th; hold cycles of result_ready=0 must leave the result stable.
    task automatic run_pass(input string tag, input logic [3:0][7:0] labs, input int gaps,
                            input bit keep_valid, input int hold, input bit start_in_done,
                            input bit start_at_hs, input int exp_label, input int exp_count,
                            input int exp_bad);
        int         lat;
        bit         stable;
        logic [7:0] lab0;
        logic [2:0] cnt0;
        logic       bad0;

        check({tag, " idle busy"}, int'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy after start"}, int'(busy), 1);

        for (int b = 0; b < int'(K); b++) begin
            if (b > 0) begin
                for (int g = 0; g < gaps; g++) begin
                    nb_valid = 1'b0;
                    nb_data  = {$urandom(), 8'd0};
                    start    = (b == 1 && g == 0);
                    tick();
                    start    = 1'b0;
                end
            end
            nb_valid = 1'b1;
            nb_data  = {$urandom(), labs[b]};
            check($sformatf("%s nb_ready beat%0d", tag, b), int'(nb_ready), 1);
            tick();
        end
        if (keep_valid) begin
            nb_data = {$urandom(), 8'd0};
        end else begin
            nb_valid = 1'b0;
        end
        check({tag, " nb_ready dropped"}, int'(nb_ready), 0);

        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (lat < 0) begin
                tick();
                if (result_valid) lat = n;
            end
        end
        nb_valid = 1'b0;
        check({tag, " latency"}, lat, int'(NL));

        lab0   = result_label;
        cnt0   = result_count;
        bad0   = bad_label;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            start = start_in_done;
            tick();
            start = 1'b0;
            if (result_valid !== 1'b1 || result_label !== lab0 ||
                result_count !== cnt0 || bad_label !== bad0) stable = 1'b0;
        end
        if (hold > 0) check({tag, " stable under backpressure"}, int'(stable), 1);

        check({tag, " result_label"}, int'(result_label), exp_label);
        check({tag, " result_count"}, int'(result_count), exp_count);
        check({tag, " bad_label"}, int'(bad_label), exp_bad);

        result_ready = 1'b1;
        start        = start_at_hs;
        tick();
        result_ready = 1'b0;
        start        = 1'b0;
        check({tag, " result_valid dropped"}, int'(result_valid), 0);
        check({tag, " busy dropped"}, int'(busy), 0);
        tick();
        check({tag, " still idle"}, int'(busy), 0);
        check({tag, " label kept"}, int'(result_label), exp_label);
    endtask

    initial begin
        vecs[0] = mkv(1, 1, 0, 1,     1, 3, 0);  // majority
        vecs[1] = mkv(2, 0, 0, 2,     2, 2, 0);  // tie, label 2 seen first
        vecs[2] = mkv(7, 3, 3, 1,     3, 2, 1);  // one illegal label
        vecs[3] = mkv(9, 9, 200, 4,   0, 0, 1);  // all illegal
        vecs[4] = mkv(3, 2, 1, 0,     3, 1, 0);  // four-way tie, nearest is 3
        vecs[5] = mkv(0, 1, 1, 0,     0, 2, 0);  // tie, lower index also nearest
        vecs[6] = mkv(2, 2, 2, 2,     2, 4, 0);  // unanimous, full count
        vecs[7] = mkv(1, 3, 3, 1,     1, 2, 0);  // tie, nearest beats higher index

        // Reset state
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_pass($sformatf("vec%0d", i), vecs[i].labs, 0, 1'b0, 0, 1'b0, 1'b0,
                     vecs[i].exp_label, vecs[i].exp_count, vecs[i].exp_bad);
        end

        // Stalled input, extra offered beat, start pulses in COLLECT/DONE/handshake
        run_pass("stall", mkv(3, 3, 0, 1, 0, 0, 0).labs, 2, 1'b1, 5, 1'b1, 1'b1, 3, 2, 0);

        // Abort mid-COLLECT after two beats; reset must clear outputs at once
        start = 1'b1;
        tick();
        start    = 1'b0;
        nb_valid = 1'b1;
        nb_data  = {32'd5, 8'd9};
        tick();
        nb_data  = {32'd6, 8'd3};
        tick();
        nb_valid = 1'b0;
        check("abort pre bad_label", int'(bad_label), 1);
        check("abort pre busy", int'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_pass("post_reset", mkv(0, 0, 0, 3, 0, 0, 0).labs, 0, 1'b0, 0, 1'b0, 1'b0, 0, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
